// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters are enabled with the MC_CTRL_PERF_CNT_EN macro.
module mips_multicycle_control
`ifdef MC_CTRL_PERF_CNT_EN
#(
    parameter int PERF_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic [1:0]        pc_source,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              illegal_op,
`ifdef MC_CTRL_PERF_CNT_EN
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt,
`endif
    output logic [3:0]        state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RTYPE_EX = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BEQ_EX   = 4'd8;
    localparam logic [3:0] S_IMM_EX   = 4'd9;
    localparam logic [3:0] S_IMM_WB   = 4'd10;
    localparam logic [3:0] S_J_EX     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_RTYPE:               state_d = S_RTYPE_EX;
                    OP_BEQ:                 state_d = S_BEQ_EX;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMM_EX;
                    OP_J:                   state_d = S_J_EX;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ_EX:   state_d = S_FETCH;
            S_IMM_EX:   state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
            S_J_EX:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode; everything is held low while reset is asserted
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        state         = 4'd0;
        if (rst_n) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                        OP_ADDI, OP_ORI, OP_LUI, OP_J: illegal_op = 1'b0;
                        default:                       illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RTYPE_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BEQ_EX: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_IMM_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                end
                S_J_EX: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: begin
                    state = state_q;
                end
            endcase
        end else begin
            state = 4'd0;
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] cycle_cnt_q;
    logic [PERF_W-1:0] instr_cnt_q;
    logic              retire_s;

    // An instruction retires on its final transition back into FETCH
    always_comb begin
        case (state_q)
            S_MEMWB, S_RTYPE_WB, S_BEQ_EX, S_IMM_WB, S_J_EX: retire_s = 1'b1;
            S_MEMWR:                                         retire_s = mem_ready;
            default:                                         retire_s = 1'b0;
        endcase
    end

    // Free-running cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= {PERF_W{1'b0}};
            instr_cnt_q <= {PERF_W{1'b0}};
        end else begin
            cycle_cnt_q <= cycle_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
            if (retire_s) begin
                instr_cnt_q <= instr_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
            end else begin
                instr_cnt_q <= instr_cnt_q;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: the driver queues hand-computed
// per-cycle output vectors, a negedge monitor pops and compares them.
module tb_mips_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_op(illegal_op),
`ifdef MC_CTRL_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Vector layout: state, pcw, pcwc, pcsrc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, ill
    function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, input logic pcwc,
                                       input logic [1:0] pcs, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic rd,
                                       input logic m2r, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop, input logic ill);
        return {st, pcw, pcwc, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ill};
    endfunction

    logic [20:0] got_s;
    assign got_s = {state, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                    ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};

    // Monitor: compare the DUT against the oldest queued expectation each falling edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (got_s !== e.v) begin
                errors++;
                $display("FAIL %s got=%h exp=%h (state got %0d exp %0d)",
                         e.tag, got_s, e.v, got_s[20:17], e.v[20:17]);
            end
        end
    end

    task automatic step(input logic [5:0] opc, input logic rdy, input logic [20:0] e, input string tag);
        exp_t x;
        opcode    = opc;
        mem_ready = rdy;
        x.v   = e;
        x.tag = tag;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [20:0] zero_v, fetch_r, fetch_n, decode_v, decode_ill, memadr_v, memrd_v, memwb_v;
        logic [20:0] memwr_v, rtex_v, rtwb_v, beq_v, immadd_v, immori_v, immwb_v, j_v;
        logic [5:0]  lw, sw, rt, beq, ori, addi, lui, jmp, bad;
        lw = 6'b100011; sw = 6'b101011; rt = 6'b000000; beq = 6'b000100;
        ori = 6'b001101; addi = 6'b001000; lui = 6'b001111; jmp = 6'b000010; bad = 6'b111111;

        zero_v     = 21'd0;
        fetch_r    = mk(4'd0,  1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        fetch_n    = mk(4'd0,  1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        decode_v   = mk(4'd1,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
        decode_ill = mk(4'd1,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1);
        memadr_v   = mk(4'd2,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
        memrd_v    = mk(4'd3,  1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        memwb_v    = mk(4'd4,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        memwr_v    = mk(4'd5,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        rtex_v     = mk(4'd6,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
        rtwb_v     = mk(4'd7,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        beq_v      = mk(4'd8,  1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0);
        immadd_v   = mk(4'd9,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
        immori_v   = mk(4'd9,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 1'b0);
        immwb_v    = mk(4'd10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        j_v        = mk(4'd11, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
        @(posedge clk); #1;
        step(lw, 1'b1, zero_v, "reset_hold0");
        step(lw, 1'b1, zero_v, "reset_hold1");
        rst_n = 1'b1;

        // lw, no stalls: 5 cycles
        step(lw, 1'b1, fetch_r, "lw_fetch");
        step(lw, 1'b1, decode_v, "lw_decode");
        step(lw, 1'b1, memadr_v, "lw_memadr");
        step(lw, 1'b1, memrd_v, "lw_memrd");
        step(lw, 1'b1, memwb_v, "lw_memwb");
        // R-type
        step(rt, 1'b1, fetch_r, "rt_fetch");
        step(rt, 1'b1, decode_v, "rt_decode");
        step(rt, 1'b1, rtex_v, "rt_ex");
        step(rt, 1'b1, rtwb_v, "rt_wb");
        // beq
        step(beq, 1'b1, fetch_r, "beq_fetch");
        step(beq, 1'b1, decode_v, "beq_decode");
        step(beq, 1'b1, beq_v, "beq_ex");
        // sw with FETCH stall then 3-cycle MEMWR stall
        step(sw, 1'b0, fetch_n, "sw_fetch_stall0");
        step(sw, 1'b0, fetch_n, "sw_fetch_stall1");
        step(sw, 1'b1, fetch_r, "sw_fetch");
        step(sw, 1'b1, decode_v, "sw_decode");
        step(sw, 1'b1, memadr_v, "sw_memadr");
        for (int i = 0; i < 3; i++) step(sw, 1'b0, memwr_v, "sw_memwr_stall");
        step(sw, 1'b1, memwr_v, "sw_memwr_done");
        // lw with 2-cycle MEMRD stall
        step(lw, 1'b1, fetch_r, "lw2_fetch");
        step(lw, 1'b1, decode_v, "lw2_decode");
        step(lw, 1'b1, memadr_v, "lw2_memadr");
        step(lw, 1'b0, memrd_v, "lw2_memrd_stall0");
        step(lw, 1'b0, memrd_v, "lw2_memrd_stall1");
        step(lw, 1'b1, memrd_v, "lw2_memrd_done");
        step(lw, 1'b1, memwb_v, "lw2_memwb");
        // immediates
        step(ori, 1'b1, fetch_r, "ori_fetch");
        step(ori, 1'b1, decode_v, "ori_decode");
        step(ori, 1'b1, immori_v, "ori_ex");
        step(ori, 1'b1, immwb_v, "ori_wb");
        step(addi, 1'b1, fetch_r, "addi_fetch");
        step(addi, 1'b1, decode_v, "addi_decode");
        step(addi, 1'b1, immadd_v, "addi_ex");
        step(addi, 1'b1, immwb_v, "addi_wb");
        step(lui, 1'b1, fetch_r, "lui_fetch");
        step(lui, 1'b1, decode_v, "lui_decode");
        step(lui, 1'b1, immori_v, "lui_ex");
        step(lui, 1'b1, immwb_v, "lui_wb");
        // jump
        step(jmp, 1'b1, fetch_r, "j_fetch");
        step(jmp, 1'b1, decode_v, "j_decode");
        step(jmp, 1'b1, j_v, "j_ex");
        // illegal opcode: one DECODE cycle flagged, back to FETCH, not retired
        step(bad, 1'b1, fetch_r, "bad_fetch");
        step(bad, 1'b1, decode_ill, "bad_decode");
`ifdef MC_CTRL_PERF_CNT_EN
        checks++;
        if (instr_cnt !== 32'd9) begin
            errors++;
            $display("FAIL instr_cnt got=%0d exp=9", instr_cnt);
        end
`endif
        // reset pulsed in MEMRD aborts the lw at once
        step(lw, 1'b1, fetch_r, "abort_fetch");
        step(lw, 1'b1, decode_v, "abort_decode");
        step(lw, 1'b1, memadr_v, "abort_memadr");
        step(lw, 1'b0, memrd_v, "abort_memrd");
        rst_n = 1'b0;
        step(lw, 1'b1, zero_v, "abort_reset");
        rst_n = 1'b1;
        step(lw, 1'b1, fetch_r, "after_abort_fetch");
        step(lw, 1'b1, decode_v, "after_abort_decode");

        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
